// File: rtl/isp_pkg.sv
// Shared ISP definitions: FSM states, Bayer channel codes, log2 helper.
// Used by the BLC controller and the BLC datapath.
package isp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_CALC,
    ST_WAIT_EOF
  } blc_state_e;

  typedef enum logic [1:0] {
    CH_GB = 2'd0,
    CH_B  = 2'd1,
    CH_R  = 2'd2,
    CH_GR = 2'd3
  } bayer_ch_e;

  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/isp_frame_cnt.sv
// Raster h/v counters with Bayer channel, OB window and
// end-of-OB / end-of-frame flags for the current pixel position.
module isp_frame_cnt
  import isp_pkg::*;
#(
  parameter int WIDTH   = 1936,
  parameter int HEIGHT  = 1088,
  parameter int OB_ROWS = 4,
  parameter int OB_COLS = 64,
  parameter int HW      = log2c(WIDTH),
  parameter int VW      = log2c(HEIGHT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [1:0] ch_o,
  output logic       sof_o,
  output logic       ob_win_o,
  output logic       ob_end_o,
  output logic       last_o
);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_end, v_end;

  assign h_end = (h_q == HW'(WIDTH - 1));
  assign v_end = (v_q == VW'(HEIGHT - 1));

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (en_i) begin
      if (h_end) begin
        h_d = '0;
        v_d = v_end ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign ch_o     = {v_q[0], h_q[0]};
  assign sof_o    = (h_q == '0) && (v_q == '0);
  assign ob_win_o = (int'(v_q) < OB_ROWS) && (int'(h_q) < OB_COLS);
  assign ob_end_o = h_end && (v_q == VW'(OB_ROWS - 1));
  assign last_o   = h_end && v_end;

endmodule

// File: rtl/isp_blc_ctrl.sv
// Black-level controller: measures OB rows per Bayer channel, optionally
// smooths over frames, and loads black levels at each frame boundary.
module isp_blc_ctrl
  import isp_pkg::*;
#(
  parameter int BITS    = 8,
  parameter int WIDTH   = 1936,
  parameter int HEIGHT  = 1088,
  parameter int OB_ROWS = 4,
  parameter int OB_COLS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] per_raw_data,
  input  logic            per_raw_data_en,
  input  logic            auto_en,
  input  logic            smooth_en,
  input  logic [7:0]      man_gb,
  input  logic [7:0]      man_b,
  input  logic [7:0]      man_r,
  input  logic [7:0]      man_gr,
  output logic [7:0]      black_gb,
  output logic [7:0]      black_b,
  output logic [7:0]      black_r,
  output logic [7:0]      black_gr,
  output logic            frame_upd,
  output logic            busy
);

  localparam int N  = (OB_ROWS / 2) * (OB_COLS / 2);
  localparam int LN = log2c(N);
  localparam int AW = BITS + LN;
  localparam int SW = BITS + 2;

  logic [1:0] ch;
  logic       sof, ob_win, ob_end, last;

  isp_frame_cnt #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .OB_ROWS(OB_ROWS),
    .OB_COLS(OB_COLS)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (per_raw_data_en),
    .ch_o    (ch),
    .sof_o   (sof),
    .ob_win_o(ob_win),
    .ob_end_o(ob_end),
    .last_o  (last)
  );

  blc_state_e state_q, state_d;
  logic       acc_clr, acc_add, calc;

  always_comb begin
    state_d = state_q;
    acc_clr = 1'b0;
    acc_add = 1'b0;
    calc    = 1'b0;
    unique case (state_q)
      ST_IDLE:
        if (per_raw_data_en && sof) begin
          state_d = ST_ACCUM;
          acc_clr = 1'b1;
          acc_add = 1'b1;
        end
      ST_ACCUM:
        if (per_raw_data_en) begin
          acc_add = ob_win;
          if (ob_end) state_d = ST_CALC;
        end
      ST_CALC: begin
        calc    = 1'b1;
        state_d = ST_WAIT_EOF;
      end
      ST_WAIT_EOF:
        if (per_raw_data_en && last) begin
          state_d = ST_ACCUM;
          acc_clr = 1'b1;
        end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  logic [AW-1:0]   acc_q  [4];
  logic [BITS-1:0] pend_q [4];
  logic [7:0]      blk_q  [4];
  logic [7:0]      man    [4];
  logic [BITS-1:0] avg    [4];
  logic [SW-1:0]   sm     [4];
  logic [BITS-1:0] nxt    [4];
  logic            done_q, eof_q, upd_q;

  assign man[0] = man_gb;
  assign man[1] = man_b;
  assign man[2] = man_r;
  assign man[3] = man_gr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (acc_clr)
          acc_q[i] <= (acc_add && ch == 2'(i)) ? AW'(per_raw_data) : '0;
        else if (acc_add && ch == 2'(i))
          acc_q[i] <= acc_q[i] + AW'(per_raw_data);
      end
    end
  end

  // Rounded average, then optional 3:1 IIR against the live output
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      avg[i] = BITS'((acc_q[i] + AW'(N / 2)) >> LN);
      sm[i]  = SW'(3) * SW'(blk_q[i]) + SW'(avg[i]) + SW'(2);
      nxt[i] = smooth_en ? BITS'(sm[i] >> 2) : avg[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pend_q[i] <= '0;
        blk_q[i]  <= '0;
      end
      done_q <= 1'b0;
      eof_q  <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      if (calc) begin
        for (int i = 0; i < 4; i++) pend_q[i] <= nxt[i];
        done_q <= 1'b1;
      end
      eof_q <= per_raw_data_en && last;
      upd_q <= eof_q;
      if (eof_q) begin
        for (int i = 0; i < 4; i++)
          blk_q[i] <= (auto_en && done_q) ? 8'(pend_q[i]) : man[i];
      end
    end
  end

  assign black_gb  = blk_q[0];
  assign black_b   = blk_q[1];
  assign black_r   = blk_q[2];
  assign black_gr  = blk_q[3];
  assign frame_upd = upd_q;
  assign busy      = (state_q == ST_ACCUM) || (state_q == ST_CALC);

endmodule

// File: tb/tb_isp_blc_ctrl.sv
// Randomized bench for isp_blc_ctrl on a 16x8 frame with a 2x8 OB
// window, checked against a frame-level reference model.
module tb_isp_blc_ctrl;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int OR = 2;
  localparam int OC = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] per_raw_data;
  logic       per_raw_data_en;
  logic       auto_en, smooth_en;
  logic [7:0] man_gb, man_b, man_r, man_gr;
  logic [7:0] black_gb, black_b, black_r, black_gr;
  logic       frame_upd, busy;

  isp_blc_ctrl #(
    .BITS   (8),
    .WIDTH  (W),
    .HEIGHT (H),
    .OB_ROWS(OR),
    .OB_COLS(OC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .per_raw_data   (per_raw_data),
    .per_raw_data_en(per_raw_data_en),
    .auto_en        (auto_en),
    .smooth_en      (smooth_en),
    .man_gb         (man_gb),
    .man_b          (man_b),
    .man_r          (man_r),
    .man_gr         (man_gr),
    .black_gb       (black_gb),
    .black_b        (black_b),
    .black_r        (black_r),
    .black_gr       (black_gr),
    .frame_upd      (frame_upd),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] pix [H][W];
  int         mcur [4];
  int         mpend [4];
  bit         mdone;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int blk(input int i);
    case (i)
      0: return int'(black_gb);
      1: return int'(black_b);
      2: return int'(black_r);
      default: return int'(black_gr);
    endcase
  endfunction

  function automatic int man(input int i);
    case (i)
      0: return int'(man_gb);
      1: return int'(man_b);
      2: return int'(man_r);
      default: return int'(man_gr);
    endcase
  endfunction

  task automatic chk_outs(input string tag);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_ch%0d", tag, i), blk(i), mcur[i]);
  endtask

  // Random frame; optionally force constant OB values per channel
  task automatic fill(input bit cst, input int c0, input int c1,
                      input int c2, input int c3);
    int cv [4];
    cv = '{c0, c1, c2, c3};
    for (int v = 0; v < H; v++)
      for (int h = 0; h < W; h++) begin
        pix[v][h] = 8'($urandom_range(0, 255));
        if (cst && v < OR && h < OC)
          pix[v][h] = 8'(cv[(v % 2) * 2 + (h % 2)]);
      end
  endtask

  // Statistics of one full frame, as seen at the end of the OB rows
  task automatic model_frame();
    int s [4];
    int a;
    s = '{0, 0, 0, 0};
    for (int v = 0; v < OR; v++)
      for (int h = 0; h < OC; h++)
        s[(v % 2) * 2 + (h % 2)] += int'(pix[v][h]);
    for (int i = 0; i < 4; i++) begin
      a = (s[i] + 2) / 4;
      mpend[i] = smooth_en ? (3 * mcur[i] + a + 2) / 4 : a;
    end
    mdone = 1'b1;
  endtask

  task automatic model_boundary();
    for (int i = 0; i < 4; i++)
      mcur[i] = (auto_en && mdone) ? mpend[i] : man(i);
  endtask

  task automatic model_reset();
    mcur  = '{0, 0, 0, 0};
    mpend = '{0, 0, 0, 0};
    mdone = 1'b0;
  endtask

  task automatic drive_frame(input string tag, input bit gaps,
                             input int chg_at, input logic [7:0] chg_val);
    for (int idx = 0; idx < W * H; idx++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          per_raw_data_en = 1'b0;
          per_raw_data    = 8'($urandom_range(0, 255));
          cyc();
        end
      end
      per_raw_data_en = 1'b1;
      per_raw_data    = pix[idx / W][idx % W];
      if (idx == chg_at) man_gb = chg_val;
      cyc();
      if (idx == 5) chk({tag, "_busy_accum"}, busy, 1);
      if (idx == 64) begin
        chk({tag, "_busy_wait"}, busy, 0);
        chk({tag, "_upd_mid"}, frame_upd, 0);
        chk_outs({tag, "_hold"});
      end
    end
    per_raw_data_en = 1'b0;
    chk({tag, "_upd_early"}, frame_upd, 0);
    model_frame();
    model_boundary();
    cyc();
    chk({tag, "_upd"}, frame_upd, 1);
    chk_outs(tag);
    cyc();
    chk({tag, "_upd_end"}, frame_upd, 0);
  endtask

  initial begin
    rst_n           = 1'b0;
    per_raw_data    = '0;
    per_raw_data_en = 1'b0;
    auto_en         = 1'b1;
    smooth_en       = 1'b0;
    man_gb          = 8'd0;
    man_b           = 8'd0;
    man_r           = 8'd0;
    man_gr          = 8'd0;
    model_reset();

    repeat (3) cyc();
    chk_outs("rst_in");
    chk("rst_in_upd", frame_upd, 0);
    chk("rst_in_busy", busy, 0);
    rst_n = 1'b1;
    repeat (4) cyc();
    chk_outs("rst_out");
    chk("rst_out_upd", frame_upd, 0);
    chk("rst_out_busy", busy, 0);

    fill(1, 16, 20, 24, 28);
    drive_frame("const", 0, -1, 8'd0);
    chk("const_gb", black_gb, 16);
    chk("const_gr", black_gr, 28);

    fill(0, 0, 0, 0, 0);
    pix[0][0] = 8'd10;
    pix[0][2] = 8'd11;
    pix[0][4] = 8'd11;
    pix[0][6] = 8'd11;
    drive_frame("round", 0, -1, 8'd0);
    chk("round_gb", black_gb, 11);

    fill(1, 16, $urandom_range(0, 255), $urandom_range(0, 255),
         $urandom_range(0, 255));
    drive_frame("pre_sm", 0, -1, 8'd0);
    smooth_en = 1'b1;
    fill(1, 32, $urandom_range(0, 255), $urandom_range(0, 255),
         $urandom_range(0, 255));
    drive_frame("smooth", 0, -1, 8'd0);
    chk("smooth_gb", black_gb, 20);

    smooth_en = 1'b0;
    fill(0, 0, 0, 0, 0);
    drive_frame("nogap", 0, -1, 8'd0);
    drive_frame("gap", 1, -1, 8'd0);

    auto_en = 1'b0;
    man_gb  = 8'd5;
    man_b   = 8'd6;
    man_r   = 8'd7;
    man_gr  = 8'd8;
    fill(0, 0, 0, 0, 0);
    drive_frame("man", 0, -1, 8'd0);
    fill(0, 0, 0, 0, 0);
    drive_frame("man_chg", 1, 40, 8'd9);
    chk("man_chg_gb", black_gb, 9);
    chk("man_chg_b", black_b, 6);

    auto_en   = 1'b1;
    smooth_en = 1'($urandom_range(0, 1));
    fill(0, 0, 0, 0, 0);
    drive_frame("rnd", 1, -1, 8'd0);

    smooth_en = 1'b0;
    for (int idx = 0; idx < 10; idx++) begin
      per_raw_data_en = 1'b1;
      per_raw_data    = 8'($urandom_range(0, 255));
      cyc();
    end
    chk("pre_rst_busy", busy, 1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_outs("mid_rst");
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_upd", frame_upd, 0);
    per_raw_data_en = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    fill(0, 0, 0, 0, 0);
    drive_frame("post_rst", 1, -1, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/isp_blc_ctrl.md
ISP_BLC_CTRL -- requirements
Module: isp_blc_ctrl

Interface
REQ-001 Parameter BITS, default 8: raw pixel width.
REQ-002 Parameter WIDTH, default 1936: pixels per line.
REQ-003 Parameter HEIGHT, default 1088: lines per frame.
REQ-004 Parameter OB_ROWS, default 4: optical-black rows at frame top; even power of two.
REQ-005 Parameter OB_COLS, default 64: sampled columns per OB row, starting at column 0; even power of two, at most WIDTH.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 per_raw_data  input  BITS  raw Bayer pixel; valid when per_raw_data_en=1.
REQ-009 per_raw_data_en  input  1  pixel qualifier; frame starts with the first accepted pixel after reset.
REQ-010 auto_en  input  1  1 selects measured black levels, 0 selects manual values.
REQ-011 smooth_en  input  1  1 enables the temporal IIR on measured levels.
REQ-012 man_gb, man_b, man_r, man_gr  input  8 each  manual black levels.
REQ-013 black_gb, black_b, black_r, black_gr  output  8 each  black levels driving the BLC datapath.
REQ-014 frame_upd  output  1  one-cycle pulse when the black_* outputs load.
REQ-015 busy  output  1  high in ACCUM or CALC.

Function
REQ-016 h_cnt and v_cnt advance only on accepted pixels; h wraps at WIDTH-1; v increments on h wrap and wraps at HEIGHT-1.
REQ-017 Bayer channel = {v_cnt[0],h_cnt[0]}: 00 gb, 01 b, 10 r, 11 gr.
REQ-018 OB window: v_cnt < OB_ROWS and h_cnt < OB_COLS.
REQ-019 Per-channel sample count N = (OB_ROWS/2)*(OB_COLS/2); accumulator width BITS+log2(N); no overflow is possible.
REQ-020 States: IDLE, ACCUM, CALC, WAIT_EOF.
REQ-021 IDLE -> ACCUM on an accepted pixel at h=0, v=0; the four accumulators clear and that pixel is added.
REQ-022 ACCUM adds each accepted OB-window pixel to its channel accumulator; ACCUM -> CALC after the accepted pixel at v=OB_ROWS-1, h=WIDTH-1.
REQ-023 CALC lasts exactly one cycle: avg = (sum + N/2) >> log2(N), stored in pending registers.
REQ-024 With smooth_en=1: pending = (3*current_output + avg + 2) >> 2, computed at BITS+2 bits. With smooth_en=0: pending = avg.
REQ-025 CALC -> WAIT_EOF; WAIT_EOF -> ACCUM after the accepted pixel at v=HEIGHT-1, h=WIDTH-1, with the accumulators cleared.
REQ-026 Frame boundary: on the clock edge following the accepted last pixel of the frame, the outputs load pending values if auto_en=1, else man_* values; frame_upd=1 for that cycle.
REQ-027 auto_en and man_* are sampled only at the frame boundary; mid-frame changes have no effect on the outputs until the next boundary.
REQ-028 If auto_en=1 and no CALC has completed since reset, the boundary loads man_* values.
REQ-029 Output latency: frame_upd and new outputs appear 1 cycle after the last pixel's accepting edge.
REQ-030 Gaps with per_raw_data_en=0 hold all counters, accumulators and state.

Reset
REQ-031 Reset drives black_*=0, frame_upd=0, busy=0, counters=0, accumulators=0, pending=0, state=IDLE, and clears the calc-done flag.
REQ-032 Reset mid-frame discards partial statistics; measurement restarts at the next h=0, v=0 pixel.

Structure
REQ-033 State encoding, Bayer channel codes, and the log2 helper belong in shared package isp_pkg, which is also used by the BLC datapath.
REQ-034 One sub-module, isp_frame_cnt, provides the h/v counters and the last-pixel and OB-window flags; the controller instantiates it.

Verification
Bench parameters: WIDTH=16, HEIGHT=8, OB_ROWS=2, OB_COLS=8, so N=4.
REQ-035 Reset: during rst_n=0 and after release with no input, all outputs are 0 and busy=0.
REQ-036 Auto mode, constant OB pixels gb=16, b=20, r=24, gr=28, smooth_en=0: after frame 1 ends, outputs are 16/20/24/28 and frame_upd pulses for 1 cycle, 1 cycle after the last pixel.
REQ-037 Rounding: gb samples 10, 11, 11, 11 give sum 43, so black_gb=11.
REQ-038 Smoothing: black_gb=16 from the previous frame, new avg 32, smooth_en=1: black_gb=20.
REQ-039 Manual mode: auto_en=0 with man_*=5/6/7/8, then man_gb changed to 9 mid-frame: outputs read 5/6/7/8 until the boundary, then black_gb=9.
REQ-040 Gaps and reset: random per_raw_data_en gaps give results identical to the gapless run; rst_n pulsed in ACCUM forces outputs to 0 and the following full frame measures correctly.
